// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing-memory port.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | serve read hits, launch read-miss fill or write-through
// RMISS | waiting for fill data from backing memory
// WTHRU | waiting for write-through completion
// DONE  | present fill data / release the stall for one cycle
module dcache_wt #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [15:0]       hit_cnt_o,
    output logic [15:0]       miss_cnt_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, RMISS, WTHRU, DONE} state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        fill_q;

    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic               cpu_hit;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_hit;
    logic               fill_we;
    logic               upd_we;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    assign cpu_idx = addr_i[IDX_W+1:2];
    assign cpu_tag = addr_i[ADDR_W-1:IDX_W+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Line updates use the registered request address so they track the transaction in flight.
    assign req_idx = mem_addr_o[IDX_W+1:2];
    assign req_tag = mem_addr_o[ADDR_W-1:IDX_W+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign fill_we = (state_q == RMISS) && mem_ack_i;
    assign upd_we  = (state_q == WTHRU) && mem_ack_i && req_hit;

    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_rdata_i;
        end else if (upd_we) begin
            data_q[req_idx] <= mem_wdata_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            fill_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_i) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        mem_wdata_o <= wdata_i;
                        state_q     <= WTHRU;
                    end else if (rd_i && !cpu_hit) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        state_q     <= RMISS;
                    end
                end
                RMISS: begin
                    if (mem_ack_i) begin
                        valid_q[req_idx] <= 1'b1;
                        fill_q           <= mem_rdata_i;
                        mem_req_o        <= 1'b0;
                        state_q          <= DONE;
                    end
                end
                WTHRU: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        rdata_o = '0;
        case (state_q)
            IDLE: begin
                if (wr_i) begin
                    stall_o = 1'b1;
                end else if (rd_i) begin
                    if (cpu_hit) rdata_o = data_q[cpu_idx];
                    else         stall_o = 1'b1;
                end
            end
            RMISS, WTHRU: stall_o = 1'b1;
            default: begin
                // mem_we_o still holds the kind of the transaction just finished.
                if (!mem_we_o) rdata_o = fill_q;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == IDLE) && (rd_i || wr_i)) begin
            if (cpu_hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus randomized accesses
// compared against an array-based cache/memory reference model.
module tb_dcache_wt;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        rd_i = 1'b0;
    logic        wr_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] bmem    [logic [29:0]];
    int          m_hits;
    int          m_misses;

    dcache_wt #(.ADDR_W(32), .IDX_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_i        (rd_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (bmem.exists(a[31:2])) return bmem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic check_counters(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hits"}, {16'd0, hit_cnt_o}, m_hits);
        check({tag, "_misses"}, {16'd0, miss_cnt_o}, m_misses);
`else
        check({tag, "_hits"}, {16'd0, hit_cnt_o}, 32'd0);
        check({tag, "_misses"}, {16'd0, miss_cnt_o}, 32'd0);
`endif
    endtask

    // Called at posedge+1 with the DUT idle; acts as CPU and backing memory for one access.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        logic [3:0]  idx;
        logic        hit, is_ld, is_st, done;
        int          exp_stall, stalls, req_cyc, we_cyc, reads, writes;
        logic [31:0] exp_data, data;

        idx   = addr[5:2];
        hit   = m_valid[idx] && (m_tag[idx] == addr[31:6]);
        is_st = wr;
        is_ld = rd && !wr;
        exp_stall = (is_st || (is_ld && !hit)) ? 1 + lat : 0;
        exp_data  = is_ld ? (hit ? m_data[idx] : mem_word(addr)) : 32'd0;
        if (rd || wr) begin
            if (hit) m_hits++;
            else     m_misses++;
        end

        rd_i = rd; wr_i = wr; addr_i = addr; wdata_i = wdata;
        stalls = 0; req_cyc = 0; we_cyc = 0; reads = 0; writes = 0; done = 1'b0; data = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            #4;
            if (mem_req_o) begin
                req_cyc++;
                if (mem_we_o) we_cyc++;
                if (req_cyc == 1) begin
                    if (mem_we_o) writes++;
                    else          reads++;
                    check({tag, "_mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
                    if (mem_we_o) check({tag, "_mem_wdata"}, mem_wdata_o, wdata);
                end
            end
            if (!stall_o) begin
                data = rdata_o;
                done = 1'b1;
            end else begin
                stalls++;
            end
            mem_ack_i   = mem_req_o && (req_cyc == lat);
            mem_rdata_i = mem_ack_i ? mem_word(mem_addr_o) : 32'd0;
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
        end
        rd_i = 1'b0; wr_i = 1'b0;

        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_stalls"}, stalls, exp_stall);
        check({tag, "_rdata"}, data, exp_data);
        check({tag, "_reads"}, reads, (is_ld && !hit) ? 1 : 0);
        check({tag, "_writes"}, writes, is_st ? 1 : 0);
        check({tag, "_we_cycles"}, we_cyc, is_st ? lat : 0);

        if (is_ld && !hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[31:6];
            m_data[idx]  = exp_data;
        end
        if (is_st) begin
            bmem[addr[31:2]] = wdata;
            if (hit) m_data[idx] = wdata;
        end
        check_counters(tag);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rd_i = 1'b0; wr_i = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        int op, lat;

        rst_i = 1'b1;
        #2;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        @(posedge clk_i);
        #1;
        model_reset();
        rst_i = 1'b0;
        check_counters("rst");

        // Miss then hit on 0x40
        bmem[30'h10] = 32'hDEAD_BEEF;
        run_access("ld40_miss", 1'b1, 1'b0, 32'h40, 32'h0, 3);
        run_access("ld40_hit", 1'b1, 1'b0, 32'h40, 32'h0, 3);

        // Write-through hit updates the line
        run_access("st40_hit", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 3);
        run_access("ld40_after_st", 1'b1, 1'b0, 32'h40, 32'h0, 2);

        // No-write-allocate
        run_access("st80_miss", 1'b0, 1'b1, 32'h80, 32'hCAFE_0080, 2);
        run_access("ld80_miss", 1'b1, 1'b0, 32'h80, 32'h0, 1);

        // Aliasing on index 0
        do_reset();
        bmem[30'h110] = 32'h0440_0440;
        run_access("alias_a", 1'b1, 1'b0, 32'h040, 32'h0, 2);
        run_access("alias_b", 1'b1, 1'b0, 32'h440, 32'h0, 2);
        run_access("alias_c", 1'b1, 1'b0, 32'h040, 32'h0, 2);
`ifdef DCACHE_STATS_EN
        check("alias_miss_cnt", {16'd0, miss_cnt_o}, 32'd3);
        check("alias_hit_cnt", {16'd0, hit_cnt_o}, 32'd0);
`endif

        // Reset while a read miss is outstanding, followed by a late ack
        rd_i = 1'b1; addr_i = 32'h2C0;
        #4;
        check("rstmid_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check("rstmid_req_before", {31'd0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rstmid_req_drop", {31'd0, mem_req_o}, 32'd0);
        rd_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h0BAD_0BAD;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        check("late_ack_req", {31'd0, mem_req_o}, 32'd0);
        check("late_ack_stall", {31'd0, stall_o}, 32'd0);
        run_access("rstmid_reload", 1'b1, 1'b0, 32'h2C0, 32'h0, 2);

        // rd and wr together is a store
        run_access("ld40_prep", 1'b1, 1'b0, 32'h40, 32'h0, 1);
        run_access("rdwr40", 1'b1, 1'b1, 32'h40, 32'hA5A5_1111, 2);
        run_access("ld40_after_rdwr", 1'b1, 1'b0, 32'h40, 32'h0, 1);

        // Randomized traffic over a small aliasing address set
        for (int n = 0; n < 80; n++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            d = $urandom;
            lat = $urandom_range(1, 4);
            op = $urandom_range(0, 9);
            if (op == 0)      run_access("rnd_idle", 1'b0, 1'b0, a, d, lat);
            else if (op <= 5) run_access("rnd_ld", 1'b1, 1'b0, a, d, lat);
            else if (op <= 8) run_access("rnd_st", 1'b0, 1'b1, a, d, lat);
            else              run_access("rnd_rdwr", 1'b1, 1'b1, a, d, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle CPU's load/store path and a multi-cycle backing data memory. The CPU supplies the ALU result as the address and the RT value as store data. The block returns load data and asserts `stall_o` to freeze the PC and register writes while a miss or a write-through is outstanding. The backing memory side uses a req/ack handshake.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `IDX_W`, 4: index bits, giving 2^IDX_W one-word lines.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `rd_i`  in  1  CPU load request (MemRead).
- `wr_i`  in  1  CPU store request (MemWrite).
- `addr_i`  in  ADDR_W  byte address; bits [1:0] are ignored.
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data.
- `stall_o`  out  1  the CPU must hold its state this cycle.
- `mem_req_o`  out  1  backing memory request, registered.
- `mem_we_o`  out  1  1 = write, 0 = read; valid while `mem_req_o` is high.
- `mem_addr_o`  out  ADDR_W  word-aligned address, registered.
- `mem_wdata_o`  out  32  write data, registered.
- `mem_ack_i`  in  1  one-cycle completion pulse from the backing memory.
- `mem_rdata_i`  in  32  read data; valid while `mem_ack_i` is high.
- `hit_cnt_o`  out  16  hit counter (see Configuration).
- `miss_cnt_o`  out  16  miss counter (see Configuration).

## Operation
- Address fields:
  - index = `addr_i[IDX_W+1:2]`
  - tag = `addr_i[ADDR_W-1:IDX_W+2]`
  - each line holds a valid bit, a tag and 32 data bits.
- Hit = valid[index] and tag match.
- If `rd_i` and `wr_i` are both high, the access is treated as a store and `rd_i` is ignored.
- FSM states and transitions:
  - IDLE
    - Read hit: `rdata_o` = line data combinationally; `stall_o`=0; stay in IDLE.
    - Read miss: `stall_o`=1 combinationally. Register `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={addr[ADDR_W-1:2],2'b00}. Go to RMISS.
    - Store, hit or miss: `stall_o`=1. Register `mem_req_o`=1, `mem_we_o`=1, address and `wdata_i`. Go to WTHRU.
    - No request: `stall_o`=0, `rdata_o`=0.
  - RMISS: hold all `mem_*` outputs and `stall_o`=1 until `mem_ack_i`. On ack:
    - write line = {1, tag, `mem_rdata_i`};
    - capture the data into `fill_q`;
    - drop `mem_req_o`;
    - go to DONE.
  - WTHRU: hold outputs and `stall_o`=1 until `mem_ack_i`. On ack:
    - if the line currently hits, update its data with the store data; otherwise leave the line unchanged (no allocate);
    - drop `mem_req_o`;
    - go to DONE.
  - DONE:
    - `stall_o`=0;
    - `rdata_o`=`fill_q` for a load; don't-care (0) for a store;
    - no new request is issued this cycle;
    - go to IDLE unconditionally.
- `mem_ack_i` outside RMISS/WTHRU is ignored.
- `mem_ack_i` in the same cycle the request first goes high is legal and completes the transaction.

## Timing
- Read hit: 0 stall cycles.
- Read miss with backing memory latency L (ack asserted L cycles after `mem_req_o` rises, L≥1): `stall_o` is high for 1+L cycles; data is presented in the DONE cycle.
- Store: same as a miss, 1+L stall cycles, for both hit and miss.
- Reset values, applied asynchronously:
  - state = IDLE;
  - all valid bits = 0 (tags and data need not be reset);
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0;
  - `fill_q`=0;
  - counters = 0;
  - `stall_o` and `rdata_o` follow IDLE decode.
- Reset in RMISS or WTHRU: `mem_req_o` drops immediately, the transaction is abandoned and no line is written. A late ack after reset is ignored.
- Index wrap: addresses differing only in tag alias to the same line. A fill overwrites the resident line; there is no dirty state.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt_o` increments once per IDLE-cycle hit (read or store);
  - `miss_cnt_o` increments once per IDLE-cycle miss (read or store);
  - both counters saturate at 16'hFFFF.
- `DCACHE_STATS_EN` undefined: both ports tied to 0 and no counter flops are synthesized.

## Test plan
- Reset, then load 0x0000_0040 with backing memory returning 0xDEAD_BEEF at L=3 → `stall_o` high 4 cycles, `rdata_o`=0xDEAD_BEEF in DONE; repeat the load → 0 stalls, same data.
- Store 0x1234_5678 to 0x40 while the line is resident → `mem_we_o`=1 for 3 cycles at `mem_addr_o`=0x40; a following load hits and returns 0x1234_5678.
- Store to 0x80 (miss) → write-through only; a following load of 0x80 misses and issues a read.
- Aliasing with IDX_W=4: load 0x040, then 0x440, then 0x040 → three misses, last returns the backing value; with `DCACHE_STATS_EN`, `miss_cnt_o`=3 and `hit_cnt_o`=0.
- Assert `rst_i` mid-RMISS, then ack → `mem_req_o`=0 immediately, the following load of the same address misses, no line written.
- `rd_i`=`wr_i`=1 at 0x40 → one write transaction (`mem_we_o`=1) and no read request.
